// File: rtl/uart_imem_loader.sv
// UART boot loader: receives an 0xA5-framed, length-prefixed image over 8N1 serial
// and writes it word by word into instruction memory, releasing the CPU when done.
module uart_imem_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int INST_MEM_N   = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx,
    output logic                  imem_we,
    output logic [INST_MEM_N-1:0] imem_addr,
    output logic [31:0]           imem_wd,
    output logic                  cpu_rst_n,
    output logic                  busy,
    output logic                  error
);
    localparam int              TW        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [TW-1:0]   T_HALF    = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0]   T_FULL    = TW'(CLKS_PER_BIT - 1);
    localparam logic [16:0]     MAX_WORDS = 17'(2 ** (INST_MEM_N - 2));
    localparam logic [7:0]      SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {S_SYNC, S_LEN_LO, S_LEN_HI, S_DATA, S_DONE} ld_state_t;

    logic                  r_rx_meta, r_rx_sync, r_rx_prev;
    rx_state_t             r_rx_state, w_rx_state_nxt;
    logic [TW-1:0]         r_tmr, w_tmr_nxt;
    logic [2:0]            r_bit_idx, w_bit_idx_nxt;
    logic [7:0]            r_shift, w_shift_nxt;
    logic                  r_byte_vld, w_byte_vld_nxt;
    logic                  r_frame_err, w_frame_err_nxt;

    ld_state_t             r_state, w_state_nxt;
    logic [15:0]           r_count, w_count_nxt;
    logic [15:0]           r_widx, w_widx_nxt;
    logic [1:0]            r_bcnt, w_bcnt_nxt;
    logic                  r_we, w_we_nxt;
    logic [INST_MEM_N-1:0] r_addr, w_addr_nxt;
    logic [31:0]           r_wd, w_wd_nxt;
    logic                  r_error, w_error_nxt;
    logic [15:0]           w_len, w_widx_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta   <= 1'b1;
            r_rx_sync   <= 1'b1;
            r_rx_prev   <= 1'b1;
            r_rx_state  <= RX_IDLE;
            r_tmr       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_byte_vld  <= 1'b0;
            r_frame_err <= 1'b0;
            r_state     <= S_SYNC;
            r_count     <= '0;
            r_widx      <= '0;
            r_bcnt      <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wd        <= '0;
            r_error     <= 1'b0;
        end else begin
            r_rx_meta   <= rx;
            r_rx_sync   <= r_rx_meta;
            r_rx_prev   <= r_rx_sync;
            r_rx_state  <= w_rx_state_nxt;
            r_tmr       <= w_tmr_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_byte_vld  <= w_byte_vld_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_widx      <= w_widx_nxt;
            r_bcnt      <= w_bcnt_nxt;
            r_we        <= w_we_nxt;
            r_addr      <= w_addr_nxt;
            r_wd        <= w_wd_nxt;
            r_error     <= w_error_nxt;
        end
    end

    // Receiver: timer is reloaded at each sample point and counts down to the next one.
    always_comb begin
        w_rx_state_nxt  = r_rx_state;
        w_tmr_nxt       = r_tmr;
        w_bit_idx_nxt   = r_bit_idx;
        w_shift_nxt     = r_shift;
        w_byte_vld_nxt  = 1'b0;
        w_frame_err_nxt = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (r_rx_prev && !r_rx_sync) begin
                    w_rx_state_nxt = RX_START;
                    w_tmr_nxt      = T_HALF;
                end
            end
            RX_START: begin
                if (r_tmr != '0) begin
                    w_tmr_nxt = r_tmr - 1'b1;
                end else if (r_rx_sync) begin
                    w_rx_state_nxt = RX_IDLE;
                end else begin
                    w_rx_state_nxt = RX_BITS;
                    w_tmr_nxt      = T_FULL;
                    w_bit_idx_nxt  = '0;
                end
            end
            RX_BITS: begin
                if (r_tmr != '0) begin
                    w_tmr_nxt = r_tmr - 1'b1;
                end else begin
                    w_shift_nxt = {r_rx_sync, r_shift[7:1]};
                    w_tmr_nxt   = T_FULL;
                    if (r_bit_idx == 3'd7) w_rx_state_nxt = RX_STOP;
                    else                   w_bit_idx_nxt  = r_bit_idx + 3'd1;
                end
            end
            RX_STOP: begin
                if (r_tmr != '0) begin
                    w_tmr_nxt = r_tmr - 1'b1;
                end else begin
                    w_rx_state_nxt  = RX_IDLE;
                    w_byte_vld_nxt  = r_rx_sync;
                    w_frame_err_nxt = !r_rx_sync;
                end
            end
            default: w_rx_state_nxt = RX_IDLE;
        endcase
    end

    assign w_len      = {r_shift, r_count[7:0]};
    assign w_widx_inc = r_widx + 16'd1;

    // Loader: the write strobe cycle is also where the word index advances.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_widx_nxt  = r_widx;
        w_bcnt_nxt  = r_bcnt;
        w_we_nxt    = 1'b0;
        w_addr_nxt  = r_addr;
        w_wd_nxt    = r_wd;
        w_error_nxt = r_error;
        if (r_frame_err) begin
            w_state_nxt = S_SYNC;
            w_error_nxt = 1'b1;
            w_bcnt_nxt  = '0;
        end else if (r_we) begin
            w_widx_nxt = w_widx_inc;
            if (w_widx_inc == r_count) w_state_nxt = S_DONE;
        end else if (r_byte_vld) begin
            case (r_state)
                S_SYNC, S_DONE: begin
                    if (r_shift == SYNC_BYTE) begin
                        w_state_nxt = S_LEN_LO;
                        w_error_nxt = 1'b0;
                        w_widx_nxt  = '0;
                        w_bcnt_nxt  = '0;
                    end
                end
                S_LEN_LO: begin
                    w_count_nxt[7:0] = r_shift;
                    w_state_nxt      = S_LEN_HI;
                end
                S_LEN_HI: begin
                    w_count_nxt = w_len;
                    if ({1'b0, w_len} > MAX_WORDS) begin
                        w_error_nxt = 1'b1;
                        w_state_nxt = S_SYNC;
                    end else if (w_len == 16'd0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end
                S_DATA: begin
                    w_wd_nxt   = {r_shift, r_wd[31:8]};
                    w_bcnt_nxt = r_bcnt + 2'd1;
                    if (r_bcnt == 2'd3) begin
                        w_we_nxt   = 1'b1;
                        w_addr_nxt = {r_widx[INST_MEM_N-3:0], 2'b00};
                    end
                end
                default: w_state_nxt = S_SYNC;
            endcase
        end
    end

    assign imem_we   = r_we;
    assign imem_addr = r_addr;
    assign imem_wd   = r_wd;
    assign error     = r_error;
    assign cpu_rst_n = (r_state == S_DONE);
    assign busy      = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) || (r_state == S_DATA);
endmodule

// File: tb/tb_uart_imem_loader.sv
// Bench for uart_imem_loader: directed packets plus random images; expected writes
// are queued per packet and matched by a monitor on each imem_we strobe.
module tb_uart_imem_loader;
    localparam int CPB = 16;
    localparam int N   = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx = 1'b1;
    logic          imem_we;
    logic [N-1:0]  imem_addr;
    logic [31:0]   imem_wd;
    logic          cpu_rst_n, busy, error;

    uart_imem_loader #(.CLKS_PER_BIT(CPB), .INST_MEM_N(N)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wd(imem_wd),
        .cpu_rst_n(cpu_rst_n), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [31:0] wd; } wr_t;
    wr_t        exp_q[$];
    wr_t        mon_e;
    logic [7:0] pkt[$];
    int         total = 0;
    int         bad = 0;
    logic       prev_we = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (imem_we) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %h data %h expected none", imem_addr, imem_wd);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(imem_addr), mon_e.addr);
                check("wr_data", imem_wd, mon_e.wd);
            end
            check("we_one_cycle", 32'(prev_we), 32'd0);
        end
        prev_we = imem_we;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        rx = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cyc(CPB);
        end
        rx = stop;
        wait_cyc(CPB);
        rx = 1'b1;
        wait_cyc(4);
    endtask

    task automatic send_pkt();
        foreach (pkt[i]) send_byte(pkt[i]);
    endtask

    task automatic exp_wr(input int addr, input logic [31:0] wd);
        wr_t e;
        e.addr = 32'(addr);
        e.wd   = wd;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"},   32'(imem_we), 0);
        check({tag, "_addr"}, 32'(imem_addr), 0);
        check({tag, "_wd"},   imem_wd, 0);
        check({tag, "_cpu"},  32'(cpu_rst_n), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_err"},  32'(error), 0);
    endtask

    initial begin
        int         n_words, n_junk, len;
        logic [31:0] w;
        logic [7:0]  jb;

        wait_cyc(3);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        wait_cyc(5);

        // Two-word image
        exp_wr(0, 32'h00100513);
        exp_wr(4, 32'h00200593);
        pkt = '{8'hA5, 8'h02, 8'h00};
        send_pkt();
        check("load_busy", 32'(busy), 1);
        check("load_cpu_held", 32'(cpu_rst_n), 0);
        pkt = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        send_pkt();
        check("two_cpu_run", 32'(cpu_rst_n), 1);
        check("two_busy", 32'(busy), 0);
        check("two_err", 32'(error), 0);
        check("two_drained", 32'(exp_q.size()), 0);

        // Zero-length reload from DONE
        pkt = '{8'hA5};
        send_pkt();
        check("reload_cpu_low", 32'(cpu_rst_n), 0);
        check("reload_busy", 32'(busy), 1);
        pkt = '{8'h00};
        send_pkt();
        check("zero_len_mid", 32'(cpu_rst_n), 0);
        pkt = '{8'h00};
        send_pkt();
        check("zero_len_cpu", 32'(cpu_rst_n), 1);
        check("zero_len_busy", 32'(busy), 0);

        // Oversize length, then recovery
        pkt = '{8'hA5, 8'h81, 8'h00};
        send_pkt();
        check("oversize_err", 32'(error), 1);
        check("oversize_cpu", 32'(cpu_rst_n), 0);
        check("oversize_busy", 32'(busy), 0);
        pkt = '{8'hA5};
        send_pkt();
        check("err_clear_a5", 32'(error), 0);
        exp_wr(0, 32'hDEADBEEF);
        pkt = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_pkt();
        check("recover_cpu", 32'(cpu_rst_n), 1);
        check("recover_err", 32'(error), 0);

        // Framing error mid-word
        pkt = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22};
        send_pkt();
        send_byte(8'h33, 1'b0);
        check("frame_err", 32'(error), 1);
        check("frame_busy", 32'(busy), 0);
        check("frame_cpu", 32'(cpu_rst_n), 0);

        // Short low glitch inside a word must not insert a byte
        pkt = '{8'hA5, 8'h01, 8'h00, 8'hAA};
        send_pkt();
        rx = 1'b0;
        wait_cyc(4);
        rx = 1'b1;
        wait_cyc(40);
        check("glitch_busy", 32'(busy), 1);
        check("glitch_err", 32'(error), 0);
        exp_wr(0, 32'hDDCCBBAA);
        pkt = '{8'hBB, 8'hCC, 8'hDD};
        send_pkt();
        check("glitch_cpu", 32'(cpu_rst_n), 1);

        // Reset mid-frame, mid-word
        pkt = '{8'hA5, 8'h01, 8'h00, 8'h55, 8'h66};
        send_pkt();
        fork
            send_byte(8'h77);
            begin
                wait_cyc(60);
                rst_n = 1'b0;
            end
        join
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        wait_cyc(5);
        exp_wr(0, 32'h44332211);
        pkt = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        send_pkt();
        check("after_rst_cpu", 32'(cpu_rst_n), 1);

        // Random oversize length
        len = $urandom_range(129, 600);
        pkt = '{8'hA5, 8'(len), 8'(len >> 8)};
        send_pkt();
        check("rnd_oversize_err", 32'(error), 1);
        check("rnd_oversize_cpu", 32'(cpu_rst_n), 0);

        // Random images preceded by ignored junk bytes
        for (int p = 0; p < 4; p++) begin
            n_junk = $urandom_range(0, 2);
            pkt.delete();
            for (int j = 0; j < n_junk; j++) begin
                jb = 8'($urandom);
                if (jb == 8'hA5) jb = 8'h5A;
                pkt.push_back(jb);
            end
            n_words = $urandom_range(1, 3);
            pkt.push_back(8'hA5);
            pkt.push_back(8'(n_words));
            pkt.push_back(8'h00);
            for (int k = 0; k < n_words; k++) begin
                w = $urandom;
                exp_wr(4 * k, w);
                for (int b = 0; b < 4; b++) pkt.push_back(8'(w >> (8 * b)));
            end
            send_pkt();
            check("rnd_cpu", 32'(cpu_rst_n), 1);
            check("rnd_err", 32'(error), 0);
            check("rnd_busy", 32'(busy), 0);
            check("rnd_drained", 32'(exp_q.size()), 0);
        end

        wait_cyc(10);
        check("final_queue_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_imem_loader.md
UART_IMEM_LOADER -- requirements
Module: uart_imem_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (100 MHz / 115200).
REQ-002 SHALL have parameter INST_MEM_N, default 9, instruction-memory byte-address width.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on posedge clk.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rx  input  1  UART serial line (8N1, idle high, LSB first), asynchronous to clk.
REQ-006 SHALL have port imem_we  output  1  one-cycle write strobe to instruction memory.
REQ-007 SHALL have port imem_addr  output  INST_MEM_N  byte address of written word (multiple of 4).
REQ-008 SHALL have port imem_wd  output  32  word written to instruction memory.
REQ-009 SHALL have port cpu_rst_n  output  1  low holds processor (PC) in reset; high lets it run.
REQ-010 SHALL have port busy  output  1  high while a load is in progress (states LEN_LO, LEN_HI, DATA).
REQ-011 SHALL have port error  output  1  sticky flag: framing error or oversize length.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer (reset value 1) before any use.
REQ-013 Receiver SHALL detect start on a synchronized high-to-low transition while idle, then resample at CLKS_PER_BIT/2 cycles; if high, the start is a glitch and the receiver returns to idle with no byte.
REQ-014 Receiver SHALL sample the 8 data bits and the stop bit each CLKS_PER_BIT cycles after the previous sample point; the bit counter SHALL count 0..7 and not wrap mid-frame.
REQ-015 Stop bit 1 SHALL produce a one-cycle internal byte-valid pulse; stop bit 0 SHALL set error, discard the byte, and force the loader FSM to SYNC.
REQ-016 Loader FSM states: SYNC, LEN_LO, LEN_HI, DATA, DONE.
REQ-017 SYNC: byte 0xA5 -> LEN_LO; any other byte ignored.
REQ-018 LEN_LO stores count[7:0] -> LEN_HI; LEN_HI stores count[15:8] -> DATA, or DONE if count = 0.
REQ-019 If count > 2^INST_MEM_N/4 at LEN_HI, SHALL set error and return to SYNC without writing memory.
REQ-020 DATA: bytes assembled little-endian (first byte -> imem_wd[7:0]); on the 4th byte, imem_we SHALL pulse exactly one cycle, the cycle after that byte-valid, with imem_addr = 4 x word index (first word at 0).
REQ-021 imem_addr/imem_wd SHALL stay stable during the imem_we pulse; word index increments after it; after the count-th word the FSM SHALL enter DONE.
REQ-022 cpu_rst_n SHALL be low in every state except DONE and SHALL rise the cycle DONE is entered.
REQ-023 DONE: byte 0xA5 SHALL drive cpu_rst_n low on the next cycle and enter LEN_LO (reload); other bytes ignored.
REQ-024 error SHALL clear only when a 0xA5 is accepted in SYNC or DONE.
REQ-025 Address arithmetic SHALL be INST_MEM_N bits wide; because the count is bounded per REQ-019, the address never wraps.

Reset
REQ-026 On rst_n low, immediately: FSM = SYNC, receiver idle, word index, byte counter and count = 0, imem_we = 0, imem_addr = 0, imem_wd = 0, cpu_rst_n = 0, busy = 0, error = 0.
REQ-027 Reset asserted mid-frame or mid-load SHALL abandon the partial word with no write; the first frame after release SHALL be treated as new.

Verification (CLKS_PER_BIT = 16, INST_MEM_N = 9)
REQ-028 Send A5 02 00 13 05 10 00 93 05 20 00 -> imem_we pulses twice: (addr 0, 0x00100513) and (addr 4, 0x00200593); cpu_rst_n rises after the second pulse; busy = 0.
REQ-029 Send A5 00 00 -> no imem_we; cpu_rst_n rises after the 3rd byte.
REQ-030 Send A5 81 00 (129 > 128 words) -> error = 1, no writes, cpu_rst_n stays 0; then send A5 01 00 EF BE AD DE -> error = 0, write (0, 0xDEADBEEF), cpu_rst_n = 1.
REQ-031 Frame with stop bit 0 during DATA -> error = 1, FSM SYNC, no write for the partial word; 4-cycle low glitch on rx -> no byte, no state change.
REQ-032 In DONE send A5 01 00 and 2 data bytes, assert rst_n -> all outputs at reset values, no imem_we; the next A5 01 00 11 22 33 44 writes (0, 0x44332211).
